// File: rtl/sc_cfg_pkg.sv
// sc_cfg_pkg: shared types and constants for the scanconverter
// config sequencer (state encoding, word indices).
package sc_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        COMMIT,
        MUTE
    } state_t;

    localparam int NUM_WORDS = 8;

    localparam logic [2:0] CFG_H_OUT  = 3'd0;
    localparam logic [2:0] CFG_H_OUT2 = 3'd1;
    localparam logic [2:0] CFG_V_OUT  = 3'd2;
    localparam logic [2:0] CFG_V_OUT2 = 3'd3;
    localparam logic [2:0] CFG_XY_OUT = 3'd4;
    localparam logic [2:0] CFG_MISC   = 3'd5;
    localparam logic [2:0] CFG_SL     = 3'd6;
    localparam logic [2:0] CFG_SL2    = 3'd7;

    // Words 0..TIMING_WORD_LAST affect output timing.
    localparam int TIMING_WORD_LAST = 4;

endpackage

// File: rtl/sc_vsync_edge.sv
// sc_vsync_edge: detects the start of output vsync (active low).
// Ports: PCLK_OUT_i, reset_i, vsync_i in; vs_start_o out (comb).
module sc_vsync_edge (
    input  logic PCLK_OUT_i,
    input  logic reset_i,
    input  logic vsync_i,
    output logic vs_start_o
);

    logic vsync_prev;

    always_ff @(posedge PCLK_OUT_i) begin
        if (reset_i) begin
            vsync_prev <= 1'b1;
        end else begin
            vsync_prev <= vsync_i;
        end
    end

    assign vs_start_o = vsync_prev & ~vsync_i;

endmodule

// File: rtl/sc_config_sequencer.sv
// sc_config_sequencer: shadow/active config banks, vsync-aligned commit,
// timeout-forced commit and frame mute after timing changes.
// Ports: PCLK_OUT_i, reset_i, wr_*, commit_req_i, vsync_i in;
// eight active config words, busy/commit_done/timeout/mute out.
// Macro SC_CFG_READBACK_EN adds rd_addr_i/rd_bank_i/rd_data_o.
module sc_config_sequencer
    import sc_cfg_pkg::*;
#(
    parameter int unsigned MUTE_FRAMES       = 2,
    parameter int unsigned TIMEOUT_CYCLES    = 2000000,
    parameter logic [31:0] RST_H_OUT_CONFIG  = 32'h0,
    parameter logic [31:0] RST_H_OUT_CONFIG2 = 32'h0,
    parameter logic [31:0] RST_V_OUT_CONFIG  = 32'h0,
    parameter logic [31:0] RST_V_OUT_CONFIG2 = 32'h0,
    parameter logic [31:0] RST_XY_OUT_CONFIG = 32'h0,
    parameter logic [31:0] RST_MISC_CONFIG   = 32'h0,
    parameter logic [31:0] RST_SL_CONFIG     = 32'h0,
    parameter logic [31:0] RST_SL_CONFIG2    = 32'h0
) (
    input  logic        PCLK_OUT_i,
    input  logic        reset_i,
    input  logic        wr_en_i,
    input  logic [2:0]  wr_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic        commit_req_i,
    input  logic        vsync_i,
`ifdef SC_CFG_READBACK_EN
    input  logic [2:0]  rd_addr_i,
    input  logic        rd_bank_i,
    output logic [31:0] rd_data_o,
`endif
    output logic [31:0] h_out_config_o,
    output logic [31:0] h_out_config2_o,
    output logic [31:0] v_out_config_o,
    output logic [31:0] v_out_config2_o,
    output logic [31:0] xy_out_config_o,
    output logic [31:0] misc_config_o,
    output logic [31:0] sl_config_o,
    output logic [31:0] sl_config2_o,
    output logic        busy_o,
    output logic        commit_done_o,
    output logic        timeout_o,
    output logic        mute_o
);

    localparam int TO_W =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] MF = 4'(MUTE_FRAMES);

    localparam logic [31:0] RST_BANK [NUM_WORDS] = '{
        RST_H_OUT_CONFIG,  RST_H_OUT_CONFIG2,
        RST_V_OUT_CONFIG,  RST_V_OUT_CONFIG2,
        RST_XY_OUT_CONFIG, RST_MISC_CONFIG,
        RST_SL_CONFIG,     RST_SL_CONFIG2
    };

    logic [31:0] shadow_q [NUM_WORDS];
    logic [31:0] active_q [NUM_WORDS];

    state_t          state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [3:0]      frm_q, frm_d;
    logic            pend_q, pend_d;
    logic            tmo_q, tmo_d;
    logic            mute_q, mute_d;
    logic            done_q, done_d;
    logic            busy_q;
    logic            load;
    logic            vs_start;
    logic            timing_changed;

    sc_vsync_edge u_vsync_edge (
        .PCLK_OUT_i (PCLK_OUT_i),
        .reset_i    (reset_i),
        .vsync_i    (vsync_i),
        .vs_start_o (vs_start)
    );

    always_comb begin
        timing_changed = 1'b0;
        for (int i = 0; i <= TIMING_WORD_LAST; i++) begin
            if (shadow_q[i] != active_q[i]) begin
                timing_changed = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        frm_d    = frm_q;
        pend_d   = pend_q;
        tmo_d    = tmo_q;
        mute_d   = mute_q;
        done_d   = 1'b0;
        load     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (commit_req_i) begin
                    state_d  = PENDING;
                    to_cnt_d = '0;
                end
            end
            PENDING: begin
                if (vs_start) begin
                    state_d = COMMIT;
                    tmo_d   = 1'b0;
                    done_d  = 1'b1;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = COMMIT;
                    tmo_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            COMMIT: begin
                load = 1'b1;
                if (timing_changed) begin
                    state_d = MUTE;
                    mute_d  = 1'b1;
                    frm_d   = '0;
                    pend_d  = commit_req_i;
                end else begin
                    // A request racing the commit is not dropped.
                    state_d  = commit_req_i ? PENDING : IDLE;
                    to_cnt_d = '0;
                    pend_d   = 1'b0;
                end
            end
            MUTE: begin
                if (commit_req_i) begin
                    pend_d = 1'b1;
                end
                if (vs_start) begin
                    frm_d = frm_q + 4'd1;
                    if (frm_q + 4'd1 >= MF) begin
                        state_d  = (pend_q | commit_req_i) ? PENDING : IDLE;
                        mute_d   = 1'b0;
                        pend_d   = 1'b0;
                        to_cnt_d = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge PCLK_OUT_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            to_cnt_q <= '0;
            frm_q    <= '0;
            pend_q   <= 1'b0;
            tmo_q    <= 1'b0;
            mute_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            frm_q    <= frm_d;
            pend_q   <= pend_d;
            tmo_q    <= tmo_d;
            mute_q   <= mute_d;
            done_q   <= done_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    // Active copies the pre-edge shadow, so a write landing on the
    // commit edge stays in shadow for the next commit.
    always_ff @(posedge PCLK_OUT_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                shadow_q[i] <= RST_BANK[i];
                active_q[i] <= RST_BANK[i];
            end
        end else begin
            if (wr_en_i) begin
                shadow_q[wr_addr_i] <= wr_data_i;
            end
            if (load) begin
                for (int i = 0; i < NUM_WORDS; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

`ifdef SC_CFG_READBACK_EN
    always_ff @(posedge PCLK_OUT_i) begin
        if (reset_i) begin
            rd_data_o <= '0;
        end else begin
            rd_data_o <= rd_bank_i ? active_q[rd_addr_i]
                                   : shadow_q[rd_addr_i];
        end
    end
`else
    // Readback disabled: no read mux.
`endif

    assign h_out_config_o  = active_q[CFG_H_OUT];
    assign h_out_config2_o = active_q[CFG_H_OUT2];
    assign v_out_config_o  = active_q[CFG_V_OUT];
    assign v_out_config2_o = active_q[CFG_V_OUT2];
    assign xy_out_config_o = active_q[CFG_XY_OUT];
    assign misc_config_o   = active_q[CFG_MISC];
    assign sl_config_o     = active_q[CFG_SL];
    assign sl_config2_o    = active_q[CFG_SL2];

    assign busy_o        = busy_q;
    assign commit_done_o = done_q;
    assign timeout_o     = tmo_q;
    assign mute_o        = mute_q;

endmodule
